retx_timer: RTL
===============

# retx_timer

Retransmission timeout timer for the TCP engine. It counts the 1 ms interval pulses from the free-running system timer and arms a timeout when a segment is sent. Each expiry doubles the timeout (exponential backoff, saturating) and raises a retransmit request. After a fixed number of retries it aborts the connection.

## Interface
- `RTO_MAX`, default 16'd6400: backoff ceiling in ms; the doubled timeout never exceeds this.
- `RETRY_MAX`, default 4'd8: number of TIMEOUT pulses allowed before ABORT.
- `CLK` in 1: system clock.
- `RST` in 1: reset. Synchronous, active-high.
- `TIM_1MS` in 1: 1 ms interval pulse from the system timer; high for one CLK cycle per ms.
- `START` in 1: one-cycle pulse; arm or re-arm the timer with `RTO_INIT`; clears the retry count.
- `STOP` in 1: one-cycle pulse; ACK received; disarm and clear.
- `RTO_INIT` in 16: initial timeout in ms, sampled only on the START cycle.
- `BUSY` out 1: timer armed (state RUN).
- `TIMEOUT` out 1: one-cycle pulse; retransmit request.
- `ABORT` out 1: one-cycle pulse; retry limit exceeded.
- `RETRY_CNT` out 4: TIMEOUT pulses since the last START.
- `RTO_CUR` out 16: currently armed timeout in ms.

## Operation
- States: IDLE, RUN.
- Registers:
  - `cnt[15:0]`: remaining ticks.
  - `rto[15:0]`: drives RTO_CUR.
  - `retry[3:0]`: drives RETRY_CNT.
- Input priority within one cycle: STOP > START > TIM_1MS.
- STOP, any state:
  - go to IDLE;
  - cnt=0, retry=0; rto unchanged;
  - no TIMEOUT or ABORT, even if the final tick lands in the same cycle.
- START, any state, without STOP:
  - go to RUN;
  - L = max(RTO_INIT,1), then L = min(L,RTO_MAX); load rto=L and cnt=L;
  - retry=0;
  - a TIM_1MS in the same cycle is ignored.
- TIM_1MS in RUN, with no START or STOP:
  - if cnt>1: cnt decrements by 1.
  - if cnt==1 and retry<RETRY_MAX (expiry): TIMEOUT pulses; retry increments; rto_next=min(2*rto, RTO_MAX); rto and cnt load rto_next; stay in RUN.
  - if cnt==1 and retry==RETRY_MAX: ABORT pulses; go to IDLE; cnt=0; retry and rto hold for diagnostics.
- Width rule: compute the doubling in 17 bits, then compare against RTO_MAX. Any 16-bit overflow saturates to RTO_MAX.
- TIM_1MS in IDLE: ignored.
- TIMEOUT and ABORT are never high in the same cycle.

## Timing
- Reset values: state=IDLE, BUSY=0, TIMEOUT=0, ABORT=0, RETRY_CNT=0, RTO_CUR=0, cnt=0.
- All outputs are registered.
- TIMEOUT and ABORT are high exactly in the cycle after the expiring TIM_1MS.
- BUSY rises in the cycle after START and falls in the cycle after STOP, or together with ABORT.
- Expiry occurs on the N-th TIM_1MS strictly after the START cycle, with N = loaded value. Real time is therefore N-1 to N ms, because the tick phase is free-running.
- RTO_CUR and RETRY_CNT update in the same cycle TIMEOUT is high.
- RST mid-operation returns to the reset values at the next edge; a pending expiry is discarded.
- No throughput restriction: START may be pulsed every cycle, and each pulse restarts the timer.

## Structure
- Shared TCP package holds:
  - state encoding `RTX_IDLE`/`RTX_RUN`;
  - `RTO_W = 16`;
  - default `RTO_MAX` and `RETRY_MAX` constants, shared with the connection FSM.
- Single module; no sub-module needed. The saturating doubler is a local expression.

## Test plan
- Reset, then START with RTO_INIT=3 and TIM_1MS every 10 cycles.
  - Required: BUSY=1 the next cycle.
  - Required: TIMEOUT exactly one cycle after the 3rd tick.
  - Required: RTO_CUR=6, RETRY_CNT=1.
- Backoff and abort, with RTO_INIT=1000, RTO_MAX=6400, RETRY_MAX=8.
  - Required: RTO_CUR sequence 2000, 4000, 6400, 6400, …
  - Required: 8 TIMEOUT pulses, then ABORT on the 9th expiry; BUSY=0, RETRY_CNT=8 afterwards.
- STOP in the same cycle as the final tick (cnt==1).
  - Required: no TIMEOUT; IDLE; RETRY_CNT=0.
- START in the same cycle as a tick while in RUN with cnt=2.
  - Required: tick ignored; cnt reloaded to RTO_INIT; RETRY_CNT=0.
- RTO_INIT=0, then separately RTO_INIT=16'hFFFF.
  - Required: 0 loads as 1, giving TIMEOUT after the first tick.
  - Required: 0xFFFF saturates to RTO_CUR=6400; 0xFFFF doubling never wraps.
- RST asserted mid-RUN with cnt=5.
  - Required: all outputs 0 the next cycle.
  - Required: subsequent ticks produce no TIMEOUT.

Source files
------------

// File: rtl/retx_timer_pkg.sv
// Shared TCP constants: retransmission timer state encoding, timeout width and
// default backoff/retry limits also used by the connection FSM.
package retx_timer_pkg;

   typedef enum logic {
      RTX_IDLE = 1'b0,
      RTX_RUN  = 1'b1
   } rtx_state_t;

   localparam int unsigned RTO_W = 16;

   localparam logic [RTO_W-1:0] RTO_MAX_DEF   = 16'd6400;
   localparam logic [3:0]       RETRY_MAX_DEF = 4'd8;

endpackage

// File: rtl/retx_timer.sv
// Retransmission timeout timer: counts 1 ms ticks after START, raises TIMEOUT
// with saturating exponential backoff, and ABORT once the retry budget is spent.
module retx_timer
   import retx_timer_pkg::*;
#(
   parameter logic [RTO_W-1:0] RTO_MAX   = RTO_MAX_DEF,
   parameter logic [3:0]       RETRY_MAX = RETRY_MAX_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             TIM_1MS,
   input  logic             START,
   input  logic             STOP,
   input  logic [RTO_W-1:0] RTO_INIT,
   output logic             BUSY,
   output logic             TIMEOUT,
   output logic             ABORT,
   output logic [3:0]       RETRY_CNT,
   output logic [RTO_W-1:0] RTO_CUR
);

   rtx_state_t       state, state_next;
   logic [RTO_W-1:0] cnt, cnt_next;
   logic [RTO_W-1:0] rto, rto_next;
   logic [3:0]       retry, retry_next;
   logic             timeout_q, timeout_next;
   logic             abort_q, abort_next;

   logic [RTO_W-1:0] load_val;
   logic [RTO_W-1:0] init_min1;
   logic [RTO_W:0]   dbl_wide;
   logic [RTO_W-1:0] dbl_sat;

   // Doubling is done one bit wider so a 16-bit overflow still saturates.
   always_comb begin
      init_min1 = (RTO_INIT == '0) ? {{(RTO_W-1){1'b0}}, 1'b1} : RTO_INIT;
      load_val  = (init_min1 > RTO_MAX) ? RTO_MAX : init_min1;
      dbl_wide  = {rto, 1'b0};
      dbl_sat   = (dbl_wide > {1'b0, RTO_MAX}) ? RTO_MAX : dbl_wide[RTO_W-1:0];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= RTX_IDLE;
         cnt       <= '0;
         rto       <= '0;
         retry     <= '0;
         timeout_q <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         rto       <= rto_next;
         retry     <= retry_next;
         timeout_q <= timeout_next;
         abort_q   <= abort_next;
      end
   end

   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      rto_next     = rto;
      retry_next   = retry;
      timeout_next = 1'b0;
      abort_next   = 1'b0;
      if (STOP) begin
         state_next = RTX_IDLE;
         cnt_next   = '0;
         retry_next = '0;
      end else if (START) begin
         state_next = RTX_RUN;
         cnt_next   = load_val;
         rto_next   = load_val;
         retry_next = '0;
      end else if (TIM_1MS && (state == RTX_RUN)) begin
         if (cnt > {{(RTO_W-1){1'b0}}, 1'b1}) begin
            cnt_next = cnt - {{(RTO_W-1){1'b0}}, 1'b1};
         end else if (retry < RETRY_MAX) begin
            timeout_next = 1'b1;
            retry_next   = retry + 4'd1;
            rto_next     = dbl_sat;
            cnt_next     = dbl_sat;
         end else begin
            // Retry and rto are kept after abort for diagnostics.
            abort_next = 1'b1;
            state_next = RTX_IDLE;
            cnt_next   = '0;
         end
      end
   end

   always_comb begin
      BUSY      = (state == RTX_RUN);
      TIMEOUT   = timeout_q;
      ABORT     = abort_q;
      RETRY_CNT = retry;
      RTO_CUR   = rto;
   end

endmodule
